// File: rtl/mc_controller_pkg.sv
// rtl/mc_controller_pkg.sv - shared encodings for the multi-cycle RV32I controller
package mc_controller_pkg;

    localparam int INSTR_BIT = 4;

    typedef enum logic [INSTR_BIT-1:0] {
        K_LUI     = 4'd0,
        K_AUIPC   = 4'd1,
        K_JAL     = 4'd2,
        K_JALR    = 4'd3,
        K_BRANCH  = 4'd4,
        K_LOAD    = 4'd5,
        K_STORE   = 4'd6,
        K_OPIMM   = 4'd7,
        K_OP      = 4'd8,
        K_ILLEGAL = 4'd9
    } kind_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic       ADDR_PC       = 1'b0;
    localparam logic       ADDR_ALUOUT   = 1'b1;
    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_ALU    = 2'd1;
    localparam logic [1:0] PC_SRC_ALU_LB = 2'd2;
    localparam logic [1:0] A_SEL_RS1     = 2'd0;
    localparam logic [1:0] A_SEL_OLD_PC  = 2'd1;
    localparam logic [1:0] A_SEL_ZERO    = 2'd2;
    localparam logic       B_SEL_RS2     = 1'b0;
    localparam logic       B_SEL_IMM     = 1'b1;
    localparam logic [1:0] WB_ALUOUT     = 2'd0;
    localparam logic [1:0] WB_MEM        = 2'd1;
    localparam logic [1:0] WB_LINK       = 2'd2;

    // alt selects SUB at funct3=000 and SRA at funct3=101
    function automatic alu_op_e op_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3, input logic eq,
                                          input logic lt, input logic ltu);
        case (funct3)
            3'b000:  return eq;
            3'b001:  return !eq;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// rtl/mc_controller_alu_decoder.sv - combinational ALU-op and illegal-instruction decode
module alu_decoder
    import mc_controller_pkg::*;
(
    input  logic [INSTR_BIT-1:0] kind,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    output logic [3:0]           alu_op,
    output logic                 illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (kind)
            K_OP: begin
                alu_op = op_from_funct3(funct3, funct7[5]);
                if (funct7 != 7'h00 && funct7 != 7'h20)
                    illegal = 1'b1;
                if (funct7 == 7'h20 && funct3 != 3'b000 && funct3 != 3'b101)
                    illegal = 1'b1;
            end
            K_OPIMM: begin
                // funct7 is immediate bits except for shifts; only SRAI uses bit 5
                alu_op = op_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001 && funct7 != 7'h00)
                    illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
                    illegal = 1'b1;
            end
            K_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    illegal = 1'b1;
            end
            K_LUI, K_AUIPC, K_JAL, K_JALR, K_LOAD, K_STORE: begin
                illegal = 1'b0;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle fetch/decode/exec/mem/wb sequencer for the RV32I datapath
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [INSTR_BIT-1:0] kind,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 cmp_eq,
    input  logic                 cmp_lt,
    input  logic                 cmp_ltu,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 aluout_we,
    output logic [1:0]           alu_a_sel,
    output logic                 alu_b_sel,
    output logic [3:0]           alu_op,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 halted
);

    if (WIDTH != 32) begin : g_width_check
        $error("mc_controller supports only a 32-bit datapath");
    end

    state_e     state_q, state_d;
    logic       is_load_q, is_store_q, is_link_q;
    logic [3:0] dec_op;
    logic       dec_illegal;

    alu_decoder u_alu_decoder (
        .kind    (kind),
        .funct3  (funct3),
        .funct7  (funct7),
        .alu_op  (dec_op),
        .illegal (dec_illegal)
    );

    // MEM and WB no longer look at kind, so the class is captured while the IR is decoded
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_START;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            is_link_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                is_load_q  <= (kind == K_LOAD);
                is_store_q <= (kind == K_STORE);
                is_link_q  <= (kind == K_JAL) || (kind == K_JALR);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = ADDR_PC;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_PLUS4;
        aluout_we = 1'b0;
        alu_a_sel = A_SEL_RS1;
        alu_b_sel = B_SEL_RS2;
        alu_op    = ALU_ADD;
        rf_we     = 1'b0;
        wb_sel    = WB_ALUOUT;
        halted    = 1'b0;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_PC;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_src  = PC_SRC_PLUS4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = dec_illegal ? S_HALT : S_EXEC;
            S_EXEC: begin
                aluout_we = 1'b1;
                alu_op    = dec_op;
                alu_b_sel = B_SEL_IMM;
                state_d   = S_WB;
                case (kind)
                    K_OP:    alu_b_sel = B_SEL_RS2;
                    K_LUI:   alu_a_sel = A_SEL_ZERO;
                    K_AUIPC: alu_a_sel = A_SEL_OLD_PC;
                    K_LOAD, K_STORE: state_d = S_MEM;
                    K_JAL: begin
                        alu_a_sel = A_SEL_OLD_PC;
                        pc_we     = 1'b1;
                        pc_src    = PC_SRC_ALU;
                    end
                    K_JALR: begin
                        pc_we  = 1'b1;
                        pc_src = PC_SRC_ALU_LB;
                    end
                    K_BRANCH: begin
                        alu_a_sel = A_SEL_OLD_PC;
                        pc_we     = branch_taken(funct3, cmp_eq, cmp_lt, cmp_ltu);
                        pc_src    = PC_SRC_ALU;
                        state_d   = S_FETCH;
                    end
                    K_OPIMM: alu_a_sel = A_SEL_RS1;
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_ALUOUT;
                mem_we   = is_store_q;
                if (mem_ready)
                    state_d = is_store_q ? S_FETCH : S_WB;
            end
            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = is_link_q ? WB_LINK : (is_load_q ? WB_MEM : WB_ALUOUT);
                state_d = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_START;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized per-cycle check of mc_controller against an instruction-level model
module tb_mc_controller;
    import mc_controller_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] kind;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       cmp_eq, cmp_lt, cmp_ltu, mem_ready;
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we, aluout_we, alu_b_sel, rf_we, halted;
    logic [1:0] pc_src, alu_a_sel, wb_sel;
    logic [3:0] alu_op;

    int checks   = 0;
    int failures = 0;

    mc_controller #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .kind(kind), .funct3(funct3), .funct7(funct7),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .aluout_we(aluout_we), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel),
        .halted(halted)
    );

    always #5 clk = ~clk;

    wire [18:0] obs = {halted, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, aluout_we,
                       alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel};

    logic [18:0] exp_q[$];
    logic        rdy_q[$];
    logic        fld_q[$];
    string       tag_q[$];
    logic [3:0]  c_kind;
    logic [2:0]  c_f3;
    logic [6:0]  c_f7;
    logic        c_eq, c_lt, c_ltu;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] v(input logic hl, input logic mr, input logic mw,
                                      input logic as, input logic iw, input logic pw,
                                      input logic [1:0] ps, input logic aw, input logic [1:0] a,
                                      input logic b, input logic [3:0] op, input logic rw,
                                      input logic [1:0] wb);
        return {hl, mr, mw, as, iw, pw, ps, aw, a, b, op, rw, wb};
    endfunction

    function automatic bit model_illegal(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7);
        if (k == K_OP)     return !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        if (k == K_OPIMM)  return (f3 == 3'd1 && f7 != 7'h00) ||
                                  (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        if (k == K_BRANCH) return f3 == 3'd2 || f3 == 3'd3;
        return k > K_OP;
    endfunction

    function automatic logic [3:0] model_op(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7);
        logic [3:0] tab [8];
        if (k != K_OP && k != K_OPIMM) return ALU_ADD;
        tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (f3 == 3'd0 && k == K_OP && f7[5]) return ALU_SUB;
        if (f3 == 3'd5 && f7[5]) return ALU_SRA;
        return tab[f3];
    endfunction

    function automatic bit model_taken(input logic [2:0] f3, input logic eq, input logic lt, input logic ltu);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            default: return !ltu;
        endcase
    endfunction

    task automatic push(input logic [18:0] e, input logic r, input logic f, input string t);
        exp_q.push_back(e);
        rdy_q.push_back(r);
        fld_q.push_back(f);
        tag_q.push_back(t);
    endtask

    task automatic build(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7,
                         input logic eq, input logic lt, input logic ltu, input int fw, input int mw);
        logic [1:0] a, ps;
        logic       pw, b;
        bit         mem_phase;
        c_kind = k; c_f3 = f3; c_f7 = f7; c_eq = eq; c_lt = lt; c_ltu = ltu;
        for (int i = 0; i < fw; i++) push(v(0,1,0,0,0,0,0,0,0,0,0,0,0), 1'b0, 1'b0, "fetch_wait");
        push(v(0,1,0,0,1,1,0,0,0,0,0,0,0), 1'b1, 1'b0, "fetch_done");
        push('0, 1'($urandom), 1'b1, "decode");
        if (model_illegal(k, f3, f7)) begin
            for (int i = 0; i < 4; i++) push(v(1,0,0,0,0,0,0,0,0,0,0,0,0), 1'($urandom), 1'b0, "halt");
            return;
        end
        a = (k == K_OP || k == K_OPIMM || k == K_LOAD || k == K_STORE || k == K_JALR) ? 2'd0 :
            (k == K_LUI) ? 2'd2 : 2'd1;
        b  = (k != K_OP);
        pw = (k == K_JAL) || (k == K_JALR) || (k == K_BRANCH && model_taken(f3, eq, lt, ltu));
        ps = (k == K_JALR) ? 2'd2 : (k == K_JAL || k == K_BRANCH) ? 2'd1 : 2'd0;
        push(v(0,0,0,0,0,pw,ps,1,a,b,model_op(k, f3, f7),0,0), 1'($urandom), 1'b1, "exec");
        if (k == K_BRANCH) return;
        mem_phase = (k == K_LOAD || k == K_STORE);
        if (mem_phase) begin
            for (int i = 0; i < mw; i++)
                push(v(0,1,k == K_STORE,1,0,0,0,0,0,0,0,0,0), 1'b0, 1'b0, "mem_wait");
            push(v(0,1,k == K_STORE,1,0,0,0,0,0,0,0,0,0), 1'b1, 1'b0, "mem_done");
        end
        if (k == K_STORE) return;
        push(v(0,0,0,0,0,0,0,0,0,0,0,1,(k == K_LOAD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0),
             1'($urandom), 1'b0, "wb");
    endtask

    // fields are only meaningful in DECODE/EXEC; elsewhere they carry noise
    task automatic play(input int n);
        string t;
        logic [18:0] e;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            mem_ready = rdy_q.pop_front();
            if (fld_q.pop_front()) begin
                kind = c_kind; funct3 = c_f3; funct7 = c_f7;
                cmp_eq = c_eq; cmp_lt = c_lt; cmp_ltu = c_ltu;
            end else begin
                kind = 4'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
                {cmp_eq, cmp_lt, cmp_ltu} = 3'($urandom);
            end
            @(negedge clk);
            check(t, 32'(obs), 32'(e));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        exp_q.delete(); rdy_q.delete(); fld_q.delete(); tag_q.delete();
        reset_n = 1'b0;
        #1;
        check("reset_async", 32'(obs), 32'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        check("reset_hold", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push('0, 1'($urandom), 1'b0, "start");
    endtask

    task automatic run(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7,
                       input logic eq, input logic lt, input logic ltu, input int fw, input int mw);
        build(k, f3, f7, eq, lt, ltu, fw, mw);
        play(exp_q.size());
        if (model_illegal(k, f3, f7)) do_reset();
    endtask

    initial begin
        logic [3:0] k;
        logic [6:0] f7;
        int sel;
        reset_n = 1'b0; mem_ready = 1'b0; kind = '0; funct3 = '0; funct7 = '0;
        {cmp_eq, cmp_lt, cmp_ltu} = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run(K_OP,     3'd0, 7'h00, 0, 0, 0, 0, 0);
        run(K_LOAD,   3'd2, 7'h00, 0, 0, 0, 0, 3);
        run(K_BRANCH, 3'd0, 7'h00, 1, 0, 0, 0, 0);
        run(K_BRANCH, 3'd1, 7'h00, 1, 0, 0, 0, 0);
        run(K_JALR,   3'd0, 7'h00, 0, 0, 0, 1, 0);
        run(K_OP,     3'd1, 7'h20, 0, 0, 0, 0, 0);

        build(K_STORE, 3'd2, 7'h00, 0, 0, 0, 0, 5);
        play(5);
        mem_ready = 1'b0;
        do_reset();

        for (int n = 0; n < 250; n++) begin
            k   = 4'($urandom_range(0, 10));
            sel = $urandom_range(0, 5);
            f7  = (sel < 3) ? 7'h00 : (sel < 5) ? 7'h20 : 7'($urandom);
            run(k, 3'($urandom), f7, 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
        end
        play(exp_q.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
